regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file, successor to the single-write/dual-read RV32I file.
//  Two write ports (e.g. ALU + load writeback), NRD combinational read ports, optional hardwired-zero entry.
//  Asynchronous reset, plus a sequential bulk-clear engine (clr_req/busy) for soft reset / context flush.
//  Sits between decode (reads) and writeback (writes) in the core pipeline.
// PARAMETERS
//  XLEN      32   data width of each register
//  NREGS     32   number of registers (>=2, need not be a power of 2)
//  NRD       2    number of read ports (>=1)
//  ZERO_REG  1    1: entry 0 reads 0 and ignores writes; 0: entry 0 is an ordinary register
//  AW        $clog2(NREGS)  address width (derived; do not override)
// PORTS
//  clk      in   1         clock, all state updates on rising edge
//  rst_n    in   1         asynchronous active-low reset
//  clr_req  in   1         pulse: start bulk clear of all entries
//  busy     out  1         1 while bulk clear in progress
//  wen0     in   1         write enable, port 0
//  waddr0   in   AW        write address, port 0
//  wdata0   in   XLEN      write data, port 0
//  wen1     in   1         write enable, port 1 (higher priority)
//  waddr1   in   AW        write address, port 1
//  wdata1   in   XLEN      write data, port 1
//  raddr    in   NRD*AW    read addresses, port k in bits [k*AW +: AW]
//  rdata    out  NRD*XLEN  read data, port k in bits [k*XLEN +: XLEN]
// BEHAVIOUR
//  Reset (rst_n=0, async): all NREGS entries <= 0, state IDLE, clear index <= 0, busy=0. rdata thus 0.
//  Reads: combinational, zero latency, per port independent. Returns 0 when addr>=NREGS,
//   or addr==0 with ZERO_REG=1; otherwise stored value (subject to BYPASS_EN below).
//  Writes (IDLE only): committed at rising edge; visible on reads the following cycle.
//   Dropped if addr>=NREGS or (addr==0 && ZERO_REG=1).
//   wen0 && wen1 && waddr0==waddr1: port 1 data written, port 0 discarded.
//  FSM: IDLE, CLEAR.
//   IDLE: clr_req=1 -> CLEAR, idx<=0. Writes that same cycle still commit (later zeroed by walk).
//   CLEAR: each cycle mem[idx]<=0, idx<=idx+1; idx==NREGS-1 -> IDLE. busy=1 in CLEAR only,
//    i.e. exactly NREGS cycles, starting the cycle after clr_req sampled.
//   CLEAR: wen0/wen1 ignored (writes lost, no stall; upstream must honour busy). clr_req ignored.
//   CLEAR: reads return current contents (mix of zeroed and not-yet-zeroed entries).
//  rst_n asserted mid-CLEAR: immediate return to IDLE, all entries 0, busy=0.
//  idx width AW; never exceeds NREGS-1 (no wrap into unimplemented addresses).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: read port whose addr matches a same-cycle accepted write
//   returns that write's wdata combinationally (port 1 over port 0 on double match).
//   No bypass for dropped writes (x0, out-of-range, CLEAR state).
//  Undefined: reads return pre-write stored value; new data visible next cycle only.
// TESTING
//  1 Reset then read all addrs on every port -> 0; write x5=0xDEADBEEF, read x5 next cycle -> 0xDEADBEEF.
//  2 ZERO_REG=1: write x0=0x12345678 -> x0 reads 0; ZERO_REG=0 build: x0 reads 0x12345678 next cycle.
//  3 wen0/wen1 both to x7 (0x1111/0x2222) -> x7=0x2222; same-cycle read x7 -> 0x2222 with BYPASS_EN,
//    prior value without.
//  4 Fill x1..x31 with index, pulse clr_req -> busy high exactly 32 cycles; write x3=0xAA during busy
//    is lost; after busy falls all entries read 0.
//  5 Start clear, assert rst_n=0 at cycle 10 of CLEAR -> busy=0 immediately, all reads 0, new write
//    accepted first cycle after release.
//  6 NREGS=24, NRD=4: write addr 28 -> dropped; read addr 28 on any port -> 0; four distinct reads correct.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: NREGS x XLEN register file, two write ports (port 1 wins), NRD combinational read ports, bulk clear.
// Latency: reads zero-latency; writes visible next cycle (same cycle when REGFILE_BYPASS_EN is defined).
// Backpressure: none; writes while busy are dropped, so upstream must hold off until busy falls.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_req,
  output logic                busy,
  input  logic                wen0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                wen1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW:0]   NREGS_W  = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              busy_q, busy_d;
  logic [XLEN-1:0]   mem_q [NREGS];
  logic [XLEN-1:0]   mem_d [NREGS];
  logic              we0_ok, we1_ok;

  // An address is backed by storage unless it is past the end or the hardwired zero entry.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign we0_ok = wen0 && (state_q == IDLE) && addr_ok(waddr0);
  assign we1_ok = wen1 && (state_q == IDLE) && addr_ok(waddr1);

  always_comb begin
    mem_d = mem_q;
    if (state_q == CLEAR) begin
      mem_d[idx_q] = '0;
    end else begin
      if (we0_ok) mem_d[waddr0] = wdata0;
      if (we1_ok) mem_d[waddr1] = wdata1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        // Stop on the last implemented entry so idx never walks into unbacked addresses.
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      mem_q   <= mem_d;
    end
  end

  assign busy = busy_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    assign ra = raddr[k*AW +: AW];
    always_comb begin
      rd = '0;
      if (addr_ok(ra)) rd = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (we1_ok && (waddr1 == ra))      rd = wdata1;
      else if (we0_ok && (waddr0 == ra)) rd = wdata0;
`endif
    end
    assign rdata[k*XLEN +: XLEN] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default 32x32/2-read instance plus a 24-entry, 4-read, no-zero-reg instance.
// Expected read values follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic        clr_req, busy, wen0, wen1;
  logic [4:0]  waddr0, waddr1, ra0, ra1;
  logic [31:0] wdata0, wdata1;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  assign raddr = {ra1, ra0};

  // Instance B: NREGS=24, NRD=4, ZERO_REG=0
  logic         b_clr_req, b_busy, b_wen0, b_wen1;
  logic [4:0]   b_waddr0, b_waddr1;
  logic [31:0]  b_wdata0, b_wdata1;
  logic [4:0]   b_ra [4];
  logic [19:0]  b_raddr;
  logic [127:0] b_rdata;
  assign b_raddr = {b_ra[3], b_ra[2], b_ra[1], b_ra[0]};

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) u_a (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata)
  );

  regfile_mp #(.XLEN(32), .NREGS(24), .NRD(4), .ZERO_REG(0)) u_b (
    .clk(clk), .rst_n(rst_n), .clr_req(b_clr_req), .busy(b_busy),
    .wen0(b_wen0), .waddr0(b_waddr0), .wdata0(b_wdata0),
    .wen1(b_wen1), .waddr1(b_waddr1), .wdata1(b_wdata1),
    .raddr(b_raddr), .rdata(b_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        w0; logic [4:0] a0; logic [31:0] d0;
    logic        w1; logic [4:0] a1; logic [31:0] d1;
    logic [4:0]  r0; logic [4:0] r1;
    logic [31:0] e0; logic [31:0] e1;   // expected without bypass
    logic [31:0] b0; logic [31:0] b1;   // expected with bypass
  } vec_t;

  vec_t vt [12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;

    vt[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    5'd0,  5'd31, 32'h0,        32'h0,        32'h0,        32'h0};
    vt[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,    5'd5,  5'd0,  32'h0,        32'h0,        32'hDEADBEEF, 32'h0};
    vt[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[3]  = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  32'h0,    5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vt[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    5'd0,  5'd1,  32'h0,        32'h0,        32'h0,        32'h0};
    vt[5]  = '{1'b1, 5'd7,  32'h77,       1'b0, 5'd0,  32'h0,    5'd7,  5'd7,  32'h0,        32'h0,        32'h77,       32'h77};
    vt[6]  = '{1'b1, 5'd7,  32'h1111,     1'b1, 5'd7,  32'h2222, 5'd7,  5'd7,  32'h77,       32'h77,       32'h2222,     32'h2222};
    vt[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    5'd7,  5'd5,  32'h2222,     32'hDEADBEEF, 32'h2222,     32'hDEADBEEF};
    vt[8]  = '{1'b1, 5'd9,  32'hA,        1'b1, 5'd10, 32'hB,    5'd9,  5'd10, 32'h0,        32'h0,        32'hA,        32'hB};
    vt[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    5'd9,  5'd10, 32'hA,        32'hB,        32'hA,        32'hB};
    vt[10] = '{1'b1, 5'd31, 32'hF,        1'b1, 5'd9,  32'hC,    5'd31, 5'd9,  32'h0,        32'hA,        32'hF,        32'hC};
    vt[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    5'd31, 5'd9,  32'hF,        32'hC,        32'hF,        32'hC};

    rst_n = 1'b0;
    clr_req = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; ra0 = '0; ra1 = '0;
    b_clr_req = 1'b0; b_wen0 = 1'b0; b_wen1 = 1'b0;
    b_waddr0 = '0; b_waddr1 = '0; b_wdata0 = '0; b_wdata1 = '0;
    for (int k = 0; k < 4; k++) b_ra[k] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // every address on both ports reads zero after reset
    for (int a = 0; a < 32; a++) begin
      @(posedge clk); #1 ra0 = 5'(a); ra1 = 5'(31 - a);
      @(negedge clk);
      chk($sformatf("rst_rd_p0_a%0d", a), rdata[31:0],  32'h0);
      chk($sformatf("rst_rd_p1_a%0d", 31 - a), rdata[63:32], 32'h0);
    end

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      wen0 = vt[i].w0; waddr0 = vt[i].a0; wdata0 = vt[i].d0;
      wen1 = vt[i].w1; waddr1 = vt[i].a1; wdata1 = vt[i].d1;
      ra0 = vt[i].r0; ra1 = vt[i].r1;
      @(negedge clk);
      chk($sformatf("vec%0d_p0", i), rdata[31:0],  BYP ? vt[i].b0 : vt[i].e0);
      chk($sformatf("vec%0d_p1", i), rdata[63:32], BYP ? vt[i].b1 : vt[i].e1);
    end
    @(posedge clk); #1 wen0 = 1'b0; wen1 = 1'b0;

    // fill x1..x31 with their index, then bulk clear
    for (int i = 1; i < 32; i++) begin
      wen0 = 1'b1; waddr0 = 5'(i); wdata0 = 32'(i);
      @(posedge clk); #1;
    end
    wen0 = 1'b0; ra0 = 5'd31; ra1 = 5'd3;
    clr_req = 1'b1;
    @(negedge clk);
    chk("clr_req_cycle_busy", 32'(busy), 32'h0);
    chk("pre_clear_x31", rdata[31:0], 32'd31);
    @(posedge clk); #1 clr_req = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (cnt == 1) chk("mid_clear_x31_intact", rdata[31:0], 32'd31);
      @(posedge clk); #1;
      wen0 = (cnt == 20); waddr0 = 5'd3; wdata0 = 32'hAA;
    end
    chk("clear_busy_cycles", 32'(cnt), 32'd32);
    wen0 = 1'b0;
    @(negedge clk);
    chk("x3_write_during_busy_lost", rdata[63:32], 32'h0);
    for (int a = 0; a < 32; a++) begin
      @(posedge clk); #1 ra0 = 5'(a); ra1 = 5'(31 - a);
      @(negedge clk);
      chk($sformatf("post_clr_p0_a%0d", a), rdata[31:0],  32'h0);
      chk($sformatf("post_clr_p1_a%0d", 31 - a), rdata[63:32], 32'h0);
    end

    // reset in the middle of a clear
    @(posedge clk); #1 wen0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h55; ra0 = 5'd12;
    @(posedge clk); #1 wen0 = 1'b0; clr_req = 1'b1;
    @(posedge clk); #1 clr_req = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy) cnt++;
      if (cnt == 10) break;
    end
    chk("midclr_reached_cycle10", 32'(cnt), 32'd10);
    chk("midclr_x12_not_yet_zeroed", rdata[31:0], 32'h55);
    #1 rst_n = 1'b0;
    #1;
    chk("midclr_rst_busy", 32'(busy), 32'h0);
    chk("midclr_rst_x12", rdata[31:0], 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    wen0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'h99;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1 wen0 = 1'b0; ra0 = 5'd20;
    @(negedge clk);
    chk("post_rst_write_x20", rdata[31:0], 32'h99);

    // instance B: 24 entries, 4 read ports, x0 ordinary
    @(posedge clk); #1;
    b_wen0 = 1'b1; b_waddr0 = 5'd0; b_wdata0 = 32'h12345678;
    b_wen1 = 1'b1; b_waddr1 = 5'd1; b_wdata1 = 32'h11;
    b_ra[0] = 5'd28; b_ra[1] = 5'd0; b_ra[2] = 5'd1; b_ra[3] = 5'd23;
    @(negedge clk);
    chk("b_rd28_same_cycle", b_rdata[31:0], 32'h0);
    @(posedge clk); #1;
    b_wen0 = 1'b1; b_waddr0 = 5'd28; b_wdata0 = 32'hBAD;
    b_wen1 = 1'b1; b_waddr1 = 5'd23; b_wdata1 = 32'h2323;
    b_ra[0] = 5'd28; b_ra[1] = 5'd1; b_ra[2] = 5'd0; b_ra[3] = 5'd23;
    @(negedge clk);
    chk("b_c2_p0_a28", b_rdata[31:0],   32'h0);
    chk("b_c2_p1_x1",  b_rdata[63:32],  32'h11);
    chk("b_c2_p2_x0",  b_rdata[95:64],  32'h12345678);
    chk("b_c2_p3_x23", b_rdata[127:96], BYP ? 32'h2323 : 32'h0);
    @(posedge clk); #1;
    b_wen0 = 1'b1; b_waddr0 = 5'd4; b_wdata0 = 32'h44; b_wen1 = 1'b0;
    @(negedge clk);
    chk("b_c3_p0_a28", b_rdata[31:0],   32'h0);
    chk("b_c3_p3_x23", b_rdata[127:96], 32'h2323);
    @(posedge clk); #1;
    b_wen0 = 1'b0;
    b_ra[0] = 5'd4; b_ra[1] = 5'd23; b_ra[2] = 5'd28; b_ra[3] = 5'd1;
    @(negedge clk);
    chk("b_c4_p0_x4",  b_rdata[31:0],   32'h44);
    chk("b_c4_p1_x23", b_rdata[63:32],  32'h2323);
    chk("b_c4_p2_a28", b_rdata[95:64],  32'h0);
    chk("b_c4_p3_x1",  b_rdata[127:96], 32'h11);

    // clear on the 24-entry file takes exactly 24 cycles
    @(posedge clk); #1 b_clr_req = 1'b1;
    @(posedge clk); #1 b_clr_req = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!b_busy) break;
      cnt++;
    end
    chk("b_clear_busy_cycles", 32'(cnt), 32'd24);
    b_ra[0] = 5'd0; b_ra[1] = 5'd23;
    #1;
    chk("b_post_clr_x0",  b_rdata[31:0],  32'h0);
    chk("b_post_clr_x23", b_rdata[63:32], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
